instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch and next-PC sequencer. It is the producing end of the controller's instruction interface.
- Owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Presents the registered word as IR to the decoder.
- On retire, consumes the decoder's Jump/condition outputs and the datapath compare flags to select the next PC: sequential, absolute jump, or PC-relative branch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- COUNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address (current PC).
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  32  fetched instruction word.
- IR  out  32  instruction register to decoder/datapath.
- ir_valid  out  1  IR holds a fetched, not-yet-retired instruction.
- ir_ready  in  1  datapath retires IR this cycle.
- Jump  in  1  absolute jump decoded from IR.
- condition  in  3  branch condition decoded from IR.
- cmp_zero  in  1  datapath compare result == 0.
- cmp_neg  in  1  datapath compare result signed negative (rs < rt).
- pc  out  32  address of IR.
- pc_plus4  out  32  pc + 4 (link value).
- retired  out  COUNT_W  count of retired instructions.

Behaviour:
- States: FETCH, HOLD.
- Reset (async, any state or mid-handshake):
  - state=FETCH, PC=RESET_PC, IR=0, retired=0.
  - imem_req=0 and ir_valid=0 while rst is high.
  - imem_req=1 from the first clk edge after rst deasserts.
- FETCH:
  - imem_req=1, imem_addr=PC, held stable until imem_ack.
  - imem_ack may arrive in the first request cycle or after any number of wait cycles.
  - On the edge where imem_ack=1: IR<=imem_rdata, go to HOLD.
  - ir_valid=0 in FETCH.
- HOLD:
  - imem_req=0, ir_valid=1, IR and pc stable.
  - Stall indefinitely while ir_ready=0.
  - On the edge where ir_ready=1: PC<=next_pc, retired+=1 (wraps modulo 2^COUNT_W), go to FETCH.
- next_pc is evaluated only from inputs sampled in the retire cycle:
  - If Jump=1: {pc_plus4[31:28], IR[25:0], 2'b00}. Jump has priority over condition.
  - Else if taken: pc_plus4 + (sign-extend(IR[15:0]) << 2), modulo 2^32.
  - Else: pc_plus4.
- taken is decoded from condition:
  - 000: never.
  - 001: cmp_zero (eq).
  - 010: !cmp_zero (ne).
  - 011: !cmp_neg (ge).
  - 100: !cmp_neg & !cmp_zero (gt).
  - 101: cmp_neg | cmp_zero (le).
  - 110: cmp_neg (lt).
  - 111: never.
- Timing and PC arithmetic:
  - No delay slot, no speculation. Minimum 2 cycles per instruction with zero-wait memory.
  - pc_plus4 wraps at 32'hFFFF_FFFC -> 0.
  - PC[1:0] is always 00.
- Ignored inputs:
  - imem_ack outside FETCH is ignored.
  - ir_ready outside HOLD is ignored.
  - Jump, condition and the cmp flags are ignored except on the retire edge.

Test Plan:
- Reset/sequential: assert rst mid-cycle, release. Memory returns 0x2001_0005 at 0x0 and 0x0000_0000 at 0x4, both with zero wait. Required: imem_addr=0x0 then 0x4; ir_valid pulses in HOLD; retired=2; no req while rst high.
- Jump: IR=0x0800_0040 at pc=0x0000_0010 with Jump=1, condition=001, cmp_zero=1. Required: next imem_addr=0x0000_0100; Jump overrides branch.
- Branch taken/not-taken: at pc=0x20, IR[15:0]=0xFFFE, condition=001. With cmp_zero=1, next addr=0x1C. With cmp_zero=0, next addr=0x24. Repeat for codes 011, 100, 101, 110 across all (cmp_zero, cmp_neg) combinations, plus 000 and 111.
- Stalls: imem_ack delayed 3 cycles, then ir_ready held 0 for 4 cycles in HOLD. Required: imem_addr stable through the wait; IR, pc and ir_valid stable through the stall; exactly one increment of retired.
- Reset mid-operation: assert rst in FETCH during wait, and again in HOLD with ir_valid=1. Required: immediate ir_valid=0 and imem_req=0; PC=RESET_PC; the stale ack arriving during rst is not captured.
- Wrap: RESET_PC=0xFFFF_FFFC, sequential retire. Required: next imem_addr=0x0; branch offset arithmetic wraps modulo 2^32.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch and next-PC sequencer. It owns the PC, fetches words over a req/ack
// handshake, and on retire picks the next PC: sequential, absolute jump or relative branch.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        IR,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               Jump,
  input  logic [2:0]         condition,
  input  logic               cmp_zero,
  input  logic               cmp_neg,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [COUNT_W-1:0] retired
);

  // state | meaning
  // FETCH | request outstanding at PC, waiting for imem_ack
  // HOLD  | IR valid, waiting for the datapath to retire it
  typedef enum logic {FETCH, HOLD} state_t;

  state_t             state;
  logic [31:0]        pc_q;
  logic [31:0]        ir_q;
  logic [COUNT_W-1:0] retired_q;
  logic               req_q;
  logic               valid_q;
  logic               taken;
  logic [31:0]        br_off;
  logic [31:0]        next_pc;
  logic [31:0]        seq_pc;

  assign seq_pc = pc_q + 32'd4;
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_comb begin
    taken = 1'b0;
    case (condition)
      3'b001:  taken = cmp_zero;
      3'b010:  taken = !cmp_zero;
      3'b011:  taken = !cmp_neg;
      3'b100:  taken = !cmp_neg && !cmp_zero;
      3'b101:  taken = cmp_neg || cmp_zero;
      3'b110:  taken = cmp_neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = seq_pc;
    if (Jump)
      next_pc = {seq_pc[31:28], ir_q[25:0], 2'b00};
    else if (taken)
      next_pc = seq_pc + br_off;
  end

  // imem_req stays low for the first cycle after reset, so an ack seen before the
  // request is raised is never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      pc_q      <= {RESET_PC[31:2], 2'b00};
      ir_q      <= 32'd0;
      retired_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          req_q <= 1'b1;
          if (req_q && imem_ack) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            pc_q      <= {next_pc[31:2], 2'b00};
            retired_q <= retired_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            valid_q   <= 1'b0;
            req_q     <= 1'b1;
            state     <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign IR        = ir_q;
  assign ir_valid  = valid_q;
  assign pc        = pc_q;
  assign pc_plus4  = seq_pc;
  assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential, jump, branch table, stalls,
// mid-operation reset and address wrap on a second instance.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] IR;
  logic        ir_valid;
  logic        ir_ready;
  logic        Jump;
  logic [2:0]  condition;
  logic        cmp_zero;
  logic        cmp_neg;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired;

  logic        rst_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        imem_ack_w;
  logic [31:0] imem_rdata_w;
  logic [31:0] ir_w;
  logic        ir_valid_w;
  logic        ir_ready_w;
  logic        jump_w;
  logic [2:0]  condition_w;
  logic        cmp_zero_w;
  logic        cmp_neg_w;
  logic [31:0] pc_w;
  logic [31:0] pc_plus4_w;
  logic [31:0] retired_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .IR(IR), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .Jump(Jump), .condition(condition), .cmp_zero(cmp_zero),
    .cmp_neg(cmp_neg), .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .COUNT_W(32)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .IR(ir_w), .ir_valid(ir_valid_w),
    .ir_ready(ir_ready_w), .Jump(jump_w), .condition(condition_w), .cmp_zero(cmp_zero_w),
    .cmp_neg(cmp_neg_w), .pc(pc_w), .pc_plus4(pc_plus4_w), .retired(retired_w)
  );

  // Stimulus only: waits for a request, optionally holds off the ack, then acks with data.
  task automatic do_fetch(input logic [31:0] data, input int waits,
                          output logic [31:0] addr, output bit addr_stable);
    int n = 0;
    addr_stable = 1'b1;
    while (imem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      addr = 'x;
      addr_stable = 1'b0;
      return;
    end
    addr = imem_addr;
    for (int i = 0; i < waits; i++) begin
      ir_ready = 1'b1;
      @(negedge clk);
      if (imem_addr !== addr || imem_req !== 1'b1) addr_stable = 1'b0;
    end
    ir_ready   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic do_retire(input logic j, input logic [2:0] c, input logic z, input logic n);
    Jump      = j;
    condition = c;
    cmp_zero  = z;
    cmp_neg   = n;
    ir_ready  = 1'b1;
    @(negedge clk);
    ir_ready  = 1'b0;
    Jump      = 1'b0;
    condition = 3'b000;
    cmp_zero  = 1'b0;
    cmp_neg   = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] a;
    bit          st;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", ir_valid); end
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rst_req_hold: got %b want 0", imem_req); end
    checks++; if (IR !== 32'h0) begin failures++; $display("FAIL rst_ir: got %h want 0", IR); end
    checks++; if (retired !== 32'h0) begin failures++; $display("FAIL rst_retired: got %0d want 0", retired); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL post_rst_req: got %b want 1", imem_req); end
    do_fetch(32'h2001_0005, 0, a, st);
    checks++; if (a !== 32'h0) begin failures++; $display("FAIL seq_addr0: got %h want 00000000", a); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL seq_valid0: got %b want 1", ir_valid); end
    checks++; if (IR !== 32'h2001_0005) begin failures++; $display("FAIL seq_ir0: got %h want 20010005", IR); end
    do_retire(1'b0, 3'b000, 1'b0, 1'b0);
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL seq_valid_drop: got %b want 0", ir_valid); end
    do_fetch(32'h0000_0000, 0, a, st);
    checks++; if (a !== 32'h4) begin failures++; $display("FAIL seq_addr1: got %h want 00000004", a); end
    do_retire(1'b0, 3'b000, 1'b0, 1'b0);
    checks++; if (retired !== 32'd2) begin failures++; $display("FAIL seq_retired: got %0d want 2", retired); end
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL seq_addr2: got %h want 00000008", imem_addr); end
  endtask

  task automatic test_jump;
    logic [31:0] a;
    bit          st;
    do_fetch(32'h0800_0004, 0, a, st);
    do_retire(1'b1, 3'b000, 1'b0, 1'b0);
    do_fetch(32'h0800_0040, 0, a, st);
    checks++; if (a !== 32'h10) begin failures++; $display("FAIL jump_pre_addr: got %h want 00000010", a); end
    checks++; if (pc_plus4 !== 32'h14) begin failures++; $display("FAIL jump_link: got %h want 00000014", pc_plus4); end
    do_retire(1'b1, 3'b001, 1'b1, 1'b0);
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL jump_addr: got %h want 00000100", imem_addr); end
  endtask

  task automatic test_branch;
    logic [31:0] a;
    logic [31:0] exp;
    bit          st;
    // bit {cmp_zero,cmp_neg} of each entry set when the branch is taken
    logic [3:0]  tbl [8];
    tbl[0] = 4'b0000; tbl[1] = 4'b1100; tbl[2] = 4'b0011; tbl[3] = 4'b0101;
    tbl[4] = 4'b0001; tbl[5] = 4'b1110; tbl[6] = 4'b1010; tbl[7] = 4'b0000;
    do_fetch(32'h0800_0008, 0, a, st);
    do_retire(1'b1, 3'b000, 1'b0, 1'b0);
    for (int c = 0; c < 8; c++) begin
      for (int zn = 0; zn < 4; zn++) begin
        do_fetch(32'h0000_FFFE, 0, a, st);
        checks++; if (a !== 32'h20) begin failures++; $display("FAIL br_at: c=%0d zn=%0d got %h want 00000020", c, zn, a); end
        do_retire(1'b0, 3'(c), zn[1], zn[0]);
        exp = tbl[c][zn] ? 32'h1C : 32'h24;
        checks++; if (imem_addr !== exp) begin failures++; $display("FAIL br_next: c=%0d zn=%0d got %h want %h", c, zn, imem_addr, exp); end
        do_fetch(32'h0800_0008, 0, a, st);
        do_retire(1'b1, 3'b000, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_stall;
    logic [31:0] a;
    logic [31:0] r0;
    bit          st;
    r0 = retired;
    do_fetch(32'h1234_5678, 3, a, st);
    checks++; if (a !== 32'h20) begin failures++; $display("FAIL stall_addr: got %h want 00000020", a); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL stall_addr_stable: got %b want 1", st); end
    for (int i = 0; i < 4; i++) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      Jump       = 1'b1;
      @(negedge clk);
      checks++; if (IR !== 32'h1234_5678) begin failures++; $display("FAIL stall_ir: cyc=%0d got %h want 12345678", i, IR); end
      checks++; if (pc !== 32'h20) begin failures++; $display("FAIL stall_pc: cyc=%0d got %h want 00000020", i, pc); end
      checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: cyc=%0d got %b want 1", i, ir_valid); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: cyc=%0d got %b want 0", i, imem_req); end
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    Jump       = 1'b0;
    do_retire(1'b0, 3'b000, 1'b0, 1'b0);
    checks++; if (retired !== r0 + 32'd1) begin failures++; $display("FAIL stall_retired: got %0d want %0d", retired, r0 + 32'd1); end
    checks++; if (imem_addr !== 32'h24) begin failures++; $display("FAIL stall_next: got %h want 00000024", imem_addr); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] a;
    bit          st;
    @(negedge clk);
    #2 rst = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midf_req: got %b want 0", imem_req); end
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL midf_pc: got %h want 00000000", pc); end
    @(negedge clk);
    rst        = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    checks++; if (IR !== 32'h0) begin failures++; $display("FAIL midf_stale_ack: got %h want 00000000", IR); end
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL midf_valid: got %b want 0", ir_valid); end
    checks++; if (retired !== 32'h0) begin failures++; $display("FAIL midf_retired: got %0d want 0", retired); end
    do_fetch(32'hCAFE_0001, 0, a, st);
    checks++; if (a !== 32'h0) begin failures++; $display("FAIL midh_addr: got %h want 00000000", a); end
    checks++; if (ir_valid !== 1'b1) begin failures++; $display("FAIL midh_pre_valid: got %b want 1", ir_valid); end
    #2 rst = 1'b1;
    #1;
    checks++; if (ir_valid !== 1'b0) begin failures++; $display("FAIL midh_valid: got %b want 0", ir_valid); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL midh_req: got %b want 0", imem_req); end
    checks++; if (IR !== 32'h0) begin failures++; $display("FAIL midh_ir: got %h want 00000000", IR); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL midh_restart: got addr=%h req=%b want 00000000/1", imem_addr, imem_req); end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    rst_w = 1'b0;
    @(negedge clk);
    checks++; if (imem_addr_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_start: got %h want fffffffc", imem_addr_w); end
    checks++; if (pc_plus4_w !== 32'h0) begin failures++; $display("FAIL wrap_link: got %h want 00000000", pc_plus4_w); end
    imem_ack_w = 1'b1; imem_rdata_w = 32'h0;
    @(negedge clk);
    imem_ack_w = 1'b0; ir_ready_w = 1'b1;
    @(negedge clk);
    ir_ready_w = 1'b0;
    checks++; if (imem_addr_w !== 32'h0) begin failures++; $display("FAIL wrap_seq: got %h want 00000000", imem_addr_w); end
    imem_ack_w = 1'b1; imem_rdata_w = 32'h0000_FFFE;
    @(negedge clk);
    imem_ack_w = 1'b0; ir_ready_w = 1'b1; condition_w = 3'b001; cmp_zero_w = 1'b1;
    @(negedge clk);
    ir_ready_w = 1'b0; condition_w = 3'b000; cmp_zero_w = 1'b0;
    checks++; if (imem_addr_w !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_branch: got %h want fffffffc", imem_addr_w); end
    checks++; if (retired_w !== 32'd2) begin failures++; $display("FAIL wrap_retired: got %0d want 2", retired_w); end
  endtask

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b0;
    Jump = 1'b0; condition = 3'b000; cmp_zero = 1'b0; cmp_neg = 1'b0;
    rst_w = 1'b1; imem_ack_w = 1'b0; imem_rdata_w = 32'h0; ir_ready_w = 1'b0;
    jump_w = 1'b0; condition_w = 3'b000; cmp_zero_w = 1'b0; cmp_neg_w = 1'b0;
    test_reset;
    test_jump;
    test_branch;
    test_stall;
    test_reset_mid;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
